// File: rtl/vga_stream_sink.sv
// Avalon-ST sink for the face-image pixel stream: framing check, 3-bit quantisation, frame-buffer write.
// Optional FRAME_CHECKSUM_EN adds a per-frame checksum of the written pixels.
module vga_stream_sink #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    localparam int NUM_PIXELS = H_RES * V_RES,
    localparam int AW = $clog2(NUM_PIXELS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [29:0]   data,
    input  logic          startofpacket,
    input  logic          endofpacket,
    input  logic          valid,
    output logic          ready,
    input  logic          enable,
    output logic          fb_wr_en,
    output logic [AW-1:0] fb_wr_addr,
    output logic [2:0]    fb_wr_data,
    output logic          frame_done,
    output logic          frame_err,
    output logic [15:0]   frames_ok,
    output logic [15:0]   frames_bad
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]   frame_checksum
`endif
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PIXELS - 1);

    state_t        state, state_next;
    logic [AW-1:0] index, index_next, pos;
    logic          accept, in_frame, restart, last, good, bad;
    logic [2:0]    quant;

    assign ready  = ~reset & enable;
    assign accept = valid & ready;
    assign quant  = {data[29], data[19], data[9]};

    // Padding bits carry no information; collected here so they read as intentionally unused.
    logic unused_pad;
    assign unused_pad = ^{data[28:20], data[18:10], data[8:0]};

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        index_next = index;
        pos        = index;
        in_frame   = 1'b0;
        restart    = 1'b0;
        last       = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        if (accept) begin
            if (startofpacket) begin
                in_frame = 1'b1;
                pos      = '0;
                restart  = (state == ACTIVE);
            end else if (state == ACTIVE) begin
                in_frame = 1'b1;
            end
            if (in_frame) begin
                last = (pos == LAST_ADDR);
                // EOP and the last address must coincide; either one alone is a framing error.
                good = endofpacket & last & ~restart;
                bad  = restart | (endofpacket ^ last);
                if (endofpacket || last) begin
                    state_next = IDLE;
                    index_next = '0;
                end else begin
                    state_next = ACTIVE;
                    index_next = pos + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frames_ok  <= '0;
            frames_bad <= '0;
        end else begin
            fb_wr_en   <= in_frame;
            frame_done <= good;
            frame_err  <= bad;
            if (in_frame) begin
                fb_wr_addr <= pos;
                fb_wr_data <= quant;
            end
            if (good && frames_ok != 16'hFFFF)
                frames_ok <= frames_ok + 16'd1;
            if (bad && frames_bad != 16'hFFFF)
                frames_bad <= frames_bad + 16'd1;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] run_sum, sum_next;

    assign sum_next = (startofpacket ? 16'd0 : run_sum) + 16'(quant);

    always_ff @(posedge clk) begin
        if (reset) begin
            run_sum        <= '0;
            frame_checksum <= '0;
        end else begin
            if (in_frame)
                run_sum <= sum_next;
            if (good)
                frame_checksum <= sum_next;
        end
    end
`endif

endmodule

// File: tb/tb_vga_stream_sink.sv
// Self-checking bench for vga_stream_sink on a 4x2 frame, with a beat-level behavioural model.
module tb_vga_stream_sink;

    localparam int H = 4;
    localparam int V = 2;
    localparam int N = H * V;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [29:0]   data = '0;
    logic          startofpacket = 1'b0;
    logic          endofpacket = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic          enable = 1'b0;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [2:0]    fb_wr_data;
    logic          frame_done;
    logic          frame_err;
    logic [15:0]   frames_ok;
    logic [15:0]   frames_bad;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]   frame_checksum;
`endif

    vga_stream_sink #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .reset(reset), .data(data),
        .startofpacket(startofpacket), .endofpacket(endofpacket),
        .valid(valid), .ready(ready), .enable(enable),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .frame_done(frame_done), .frame_err(frame_err),
        .frames_ok(frames_ok), .frames_bad(frames_bad)
`ifdef FRAME_CHECKSUM_EN
        , .frame_checksum(frame_checksum)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level model: m_pos is the next expected pixel address, -1 while waiting for SOP.
    int m_pos = -1;
    int m_ok = 0;
    int m_bad = 0;
    int m_sum = 0;
    int m_cks = 0;

    // One clock of stimulus; pixel given as 8-bit channels, padding bits randomised.
    task automatic drive_beat(input bit rst, input bit v, input bit en,
                              input bit sop, input bit eop,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit e_wr = 0, e_done = 0, e_err = 0, restart = 0, ends;
        int pos = -1;
        logic [2:0] e_q = '0;
        logic [5:0] pad = 6'($urandom);
        reset = rst; valid = v; enable = en;
        startofpacket = sop; endofpacket = eop;
        data = {r, pad[5:4], g, pad[3:2], b, pad[1:0]};
        #1;
        vectors++;
        if (ready !== (!rst && en)) begin
            miscompares++;
            $display("FAIL ready: got %b want %b", ready, !rst && en);
        end
        if (rst) begin
            m_pos = -1; m_ok = 0; m_bad = 0; m_sum = 0; m_cks = 0;
        end else if (v && en) begin
            if (sop) begin
                restart = (m_pos >= 0);
                pos = 0;
                m_sum = 0;
            end else if (m_pos >= 0) begin
                pos = m_pos;
            end
            if (pos >= 0) begin
                e_wr = 1;
                e_q = {r[7], g[7], b[7]};
                m_sum = (m_sum + int'(e_q)) % 65536;
                ends = eop || (pos == N - 1);
                if (restart || (ends && !(eop && pos == N - 1))) e_err = 1;
                else if (ends) e_done = 1;
                m_pos = ends ? -1 : pos + 1;
                if (e_done && m_ok < 65535) m_ok++;
                if (e_err && m_bad < 65535) m_bad++;
                if (e_done) m_cks = m_sum;
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (fb_wr_en !== e_wr) begin
            miscompares++;
            $display("FAIL fb_wr_en: got %b want %b", fb_wr_en, e_wr);
        end
        if (e_wr || rst) begin
            vectors++;
            if (fb_wr_addr !== AW'(rst ? 0 : pos) || fb_wr_data !== e_q) begin
                miscompares++;
                $display("FAIL fb_write: got addr %0d data %b want addr %0d data %b",
                         fb_wr_addr, fb_wr_data, rst ? 0 : pos, e_q);
            end
        end
        vectors++;
        if (frame_done !== e_done || frame_err !== e_err) begin
            miscompares++;
            $display("FAIL pulses: got done %b err %b want done %b err %b",
                     frame_done, frame_err, e_done, e_err);
        end
        vectors++;
        if (frames_ok !== 16'(m_ok) || frames_bad !== 16'(m_bad)) begin
            miscompares++;
            $display("FAIL counters: got ok %0d bad %0d want ok %0d bad %0d",
                     frames_ok, frames_bad, m_ok, m_bad);
        end
`ifdef FRAME_CHECKSUM_EN
        vectors++;
        if (frame_checksum !== 16'(m_cks)) begin
            miscompares++;
            $display("FAIL checksum: got %h want %h", frame_checksum, 16'(m_cks));
        end
`endif
    endtask

    task automatic pixel(input bit sop, input bit eop);
        drive_beat(0, 1, 1, sop, eop, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic frame_beats(input int n, input int eop_at);
        for (int i = 0; i < n; i++) pixel(i == 0, i == eop_at);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            drive_beat(1, 1, 1, i == 0, 0, 8'hFF, 8'hFF, 8'hFF);
        vectors++;
        if (frames_ok !== 16'd0 || frames_bad !== 16'd0 || fb_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ok %0d bad %0d wr %b want 0 0 0",
                     frames_ok, frames_bad, fb_wr_en);
        end
    endtask

    task automatic test_white_frame();
        for (int i = 0; i < N; i++) drive_beat(0, 1, 1, i == 0, i == N - 1, 8'hFF, 8'hFF, 8'hFF);
        vectors++;
        if (frames_ok !== 16'd1 || frames_bad !== 16'd0) begin
            miscompares++;
            $display("FAIL white_frame: got ok %0d bad %0d want 1 0", frames_ok, frames_bad);
        end
`ifdef FRAME_CHECKSUM_EN
        vectors++;
        if (frame_checksum !== 16'(7 * N)) begin
            miscompares++;
            $display("FAIL white_checksum: got %h want %h", frame_checksum, 16'(7 * N));
        end
`endif
    endtask

    task automatic test_early_eop();
        frame_beats(6, 5);
        for (int i = 0; i < 3; i++) pixel(0, 0);
        vectors++;
        if (frames_bad !== 16'd1) begin
            miscompares++;
            $display("FAIL early_eop: got bad %0d want 1", frames_bad);
        end
    endtask

    task automatic test_restart();
        frame_beats(3, -1);
        frame_beats(N, N - 1);
        vectors++;
        if (frames_bad !== 16'd2 || frames_ok !== 16'd2) begin
            miscompares++;
            $display("FAIL restart: got ok %0d bad %0d want 2 2", frames_ok, frames_bad);
        end
    endtask

    task automatic test_missing_eop();
        frame_beats(N, -1);
        pixel(0, 0);
        pixel(0, 1);
        vectors++;
        if (frames_bad !== 16'd3) begin
            miscompares++;
            $display("FAIL missing_eop: got bad %0d want 3", frames_bad);
        end
    endtask

    task automatic test_idle_sop_eop();
        pixel(1, 1);
        vectors++;
        if (frames_bad !== 16'd4) begin
            miscompares++;
            $display("FAIL sop_eop: got bad %0d want 4", frames_bad);
        end
    endtask

    task automatic test_enable_gap();
        frame_beats(3, -1);
        for (int i = 0; i < 5; i++)
            drive_beat(0, 1, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 3; i < N; i++) pixel(0, i == N - 1);
        vectors++;
        if (frames_ok !== 16'd3) begin
            miscompares++;
            $display("FAIL enable_gap: got ok %0d want 3", frames_ok);
        end
    endtask

    task automatic test_reset_mid();
        frame_beats(4, -1);
        drive_beat(1, 1, 1, 0, 0, 8'h80, 8'h80, 8'h80);
        frame_beats(N, N - 1);
        vectors++;
        if (frames_ok !== 16'd1 || frames_bad !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got ok %0d bad %0d want 1 0", frames_ok, frames_bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            drive_beat($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
                       $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 12,
                       $urandom_range(0, 99) < 12,
                       8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_white_frame();
        test_early_eop();
        test_restart();
        test_missing_eop();
        test_idle_sop_eop();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_stream_sink.md
Name: vga_stream_sink

Overview:
- Avalon-ST sink for the 640x480, 30-bit RGB pixel stream produced by the face image source. It is the receiving end of that stream.
- Checks packet framing (SOP/EOP against pixel count), quantises each pixel to 3-bit RGB, and writes it into a frame-buffer BRAM write port.
- Exposes frame status counters. Used as a loopback checker and as capture logic for the frame buffer.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame; NUM_PIXELS = H_RES*V_RES; address width AW = $clog2(NUM_PIXELS) (19 at defaults).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data  in  30  {R[7:0],2'b00,G[7:0],2'b00,B[7:0],2'b00}.
- startofpacket  in  1  first pixel of frame.
- endofpacket  in  1  last pixel of frame.
- valid  in  1  source beat valid.
- ready  out  1  sink can accept.
- enable  in  1  capture enable; low applies backpressure.
- fb_wr_en  out  1  frame-buffer write strobe.
- fb_wr_addr  out  AW  pixel address.
- fb_wr_data  out  3  {R,G,B} quantised pixel.
- frame_done  out  1  1-cycle pulse, good frame received.
- frame_err  out  1  1-cycle pulse, framing error.
- frames_ok  out  16  good-frame counter.
- frames_bad  out  16  bad-frame counter.

Behaviour:
- Clock clk; reset is synchronous, active-high. All state is reset by reset, with no initial-value reliance.
- Reset values: ready=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, frame_err=0, frames_ok=0, frames_bad=0, pixel index=0, state=IDLE.
- ready = ~reset & enable, combinational. A beat is accepted iff valid & ready on a rising edge.
- Quantisation: fb_wr_data = {data[29], data[19], data[9]} (MSB of each 8-bit channel). Padding bits are ignored.
- Write latency: exactly 1 cycle. fb_wr_en/addr/data are registered from the accepted beat. fb_wr_en=0 in any cycle following a non-accepted cycle. The write port never stalls.
- State IDLE (waiting for SOP):
  - Accepted beat without SOP: discarded, no write.
  - Accepted beat with SOP: written to addr 0, index<=1, go ACTIVE.
  - If the SOP beat also carries EOP (and NUM_PIXELS>1): frame_err pulse, frames_bad++, stay IDLE.
- State ACTIVE (index = address of next beat):
  - Accepted beat without SOP/EOP: write at index, index++.
  - Accepted beat with EOP and index==NUM_PIXELS-1: write, frame_done pulse, frames_ok++, index<=0, go IDLE.
  - Accepted beat with EOP and index!=NUM_PIXELS-1 (early EOP): write, frame_err pulse, frames_bad++, go IDLE.
  - Accepted beat with index==NUM_PIXELS-1 and no EOP (missing EOP): write, frame_err pulse, frames_bad++, go IDLE. Following beats are discarded until the next SOP.
  - Accepted beat with SOP (restart mid-frame): frame_err pulse, frames_bad++, beat written to addr 0, index<=1, stay ACTIVE.
- frame_done and frame_err are asserted the cycle after the deciding beat, aligned with its fb_wr_en. They are never both high.
- Counters saturate at 16'hFFFF; they do not wrap.
- enable low mid-frame: state and index are held and no writes occur; the frame resumes when enable returns high.
- Reset mid-frame: returns to IDLE at index 0 next cycle. No error is counted and no pulse is issued.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined:
  - Adds output frame_checksum[15:0], reset 0.
  - A running sum mod 2^16 of zero-extended fb_wr_data over the written beats of the current frame. The sum restarts at the SOP beat.
  - frame_checksum is updated to the final sum on the same cycle frame_done pulses, and is unchanged on errors.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan:
- Default params; stream one all-white frame (data=30'h3FCFF3FC, SOP on beat 0, EOP on beat 307199), enable=1, ready=1.
  -> 307200 writes of data 3'b111 at addrs 0..307199; one frame_done; frames_ok=1; frames_bad=0. With FRAME_CHECKSUM_EN: frame_checksum=16'hD000.
- H_RES=4, V_RES=2; EOP on beat index 5.
  -> writes at addrs 0..5; frame_err pulse aligned with the addr-5 write; frames_bad=1. Then 3 non-SOP beats produce no writes.
- H_RES=4, V_RES=2; SOP again at beat 3 of a frame, followed by a valid 8-beat frame.
  -> frames_bad=1 after the SOP at beat 3; the restart SOP beat is written at addr 0; frames_ok=1 after the final EOP.
- H_RES=4, V_RES=2; beat 7 without EOP, then 2 extra beats.
  -> addr 7 written; frame_err pulse; the extra beats are not written; state returns to IDLE.
- Toggle enable low for 5 cycles at index 3, with valid high throughout.
  -> ready=0 for those 5 cycles; no writes; addresses continue at 3 after enable returns; frame_done pulses on the final beat.
- Assert reset at index 4 mid-frame, then send a full frame.
  -> outputs are all 0 the cycle after reset; frames_bad stays 0; the new frame completes with frames_ok=1.
